// File: rtl/cl_serial_ctrl_if.sv
// cl_serial_ctrl_if
//   Request/response bundle between the register bank and the bit-serial
//   sequencer cl_serial_ctrl.
//   master : register bank side (drives start/abort/op/a/b, reads status/result)
//   slave  : sequencer side
//   Signals:
//     start   request a new operation
//     abort   cancel the operation in progress
//     op      cl select: 00 AND, 01 OR, 10 XOR, 11 NOT a
//     a, b    WIDTH-bit operands
//     busy    operation in progress
//     done    one-cycle completion pulse
//     result  last completed result
interface cl_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             abort;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, abort, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, abort, op, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/cl_serial_ctrl.sv
// cl_serial_ctrl
//   Drives one shared 1-bit logic cell `cl` bit-serially (LSB first) over two
//   WIDTH-bit operands, one bit per clock, and assembles the WIDTH-bit result.
//   Ports:
//     clk     rising-edge clock
//     reset   synchronous reset, active-low
//     bus     request/response interface (slave side)
//     cl_a    bit of operand A presented to the cell (0 outside RUN)
//     cl_b    bit of operand B presented to the cell (0 outside RUN)
//     cl_s    cell function select (00 outside RUN)
//     cl_out  cell output, combinational response to cl_a/cl_b/cl_s
module cl_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    cl_serial_ctrl_if.slave bus,
    output logic            cl_a,
    output logic            cl_b,
    output logic [1:0]      cl_s,
    input  logic            cl_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] result_reg;
    logic             last_bit;

    assign last_bit = (cnt == CNT_LAST);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.start) state_next = RUN;
            // Abort wins over a completion on the final bit.
            RUN: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, bit counter and result assembly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            acc        <= '0;
            op_reg     <= 2'b00;
            result_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg  <= bus.a;
                        b_reg  <= bus.b;
                        op_reg <= bus.op;
                        cnt    <= '0;
                        acc    <= '0;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        // Partial accumulator is simply abandoned; it is
                        // cleared again on the next accepted start.
                        cnt <= '0;
                    end else begin
                        acc[cnt] <= cl_out;
                        if (last_bit) begin
                            // acc[WIDTH-1] is being written on this same edge,
                            // so the top bit comes straight from the cell.
                            result_reg <= {cl_out, acc[WIDTH-2:0]};
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Status and cell drive are pure decodes of the registered state.
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        cl_a     = 1'b0;
        cl_b     = 1'b0;
        cl_s     = 2'b00;
        case (state)
            RUN: begin
                bus.busy = 1'b1;
                cl_a     = a_reg[cnt];
                cl_b     = b_reg[cnt];
                cl_s     = op_reg;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.result = result_reg;
endmodule

// File: tb/tb_cl_serial_ctrl.sv
// tb_cl_serial_ctrl
//   Directed bench for cl_serial_ctrl (WIDTH=8) with a behavioural 1-bit cell.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_cl_serial_ctrl;
    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       cl_a;
    logic       cl_b;
    logic [1:0] cl_s;
    logic       cl_out;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] last_result;

    cl_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

    cl_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .cl_a   (cl_a),
        .cl_b   (cl_b),
        .cl_s   (cl_s),
        .cl_out (cl_out)
    );

    // Behavioural logic cell.
    always_comb begin
        case (cl_s)
            2'b00:   cl_out = cl_a & cl_b;
            2'b01:   cl_out = cl_a | cl_b;
            2'b10:   cl_out = cl_a ^ cl_b;
            default: cl_out = ~cl_a;
        endcase
    end

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full operation from start to one cycle after done. If inject_at >= 0,
    // start is reasserted with a different a/op during that RUN sample slot.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op, input logic [7:0] expected,
                          input string tag, input int inject_at);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.op    = op;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == inject_at) begin
                bus.start = 1'b1;
                bus.a     = 8'h00;
                bus.op    = 2'b11;
            end else if (i == inject_at + 1) begin
                bus.start = 1'b0;
                bus.a     = a;
                bus.op    = op;
            end
            check({tag, ":busy"},   32'(bus.busy),   32'd1);
            check({tag, ":done"},   32'(bus.done),   32'd0);
            check({tag, ":hold"},   32'(bus.result), 32'(last_result));
            check({tag, ":cl_a"},   32'(cl_a),       32'(a[i]));
            check({tag, ":cl_b"},   32'(cl_b),       32'(b[i]));
            check({tag, ":cl_s"},   32'(cl_s),       32'(op));
            step();
        end
        bus.start = 1'b0;
        check({tag, ":done_pulse"}, 32'(bus.done),   32'd1);
        check({tag, ":busy_off"},   32'(bus.busy),   32'd0);
        check({tag, ":result"},     32'(bus.result), 32'(expected));
        last_result = expected;
        step();
        check({tag, ":done_end"},   32'(bus.done),   32'd0);
        check({tag, ":result_hold"},32'(bus.result), 32'(expected));
    endtask

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        bus.op    = 2'b00;
        last_result = 8'h00;

        // Reset state
        step();
        step();
        check("rst:busy",   32'(bus.busy),   32'd0);
        check("rst:done",   32'(bus.done),   32'd0);
        check("rst:result", 32'(bus.result), 32'h0);
        check("rst:cl_a",   32'(cl_a),       32'd0);
        check("rst:cl_b",   32'(cl_b),       32'd0);
        check("rst:cl_s",   32'(cl_s),       32'd0);
        reset = 1'b1;
        step();
        check("idle:busy",  32'(bus.busy),   32'd0);

        // AND with a start/a change injected during RUN cycle 3
        run_op(8'hA5, 8'h0F, 2'b00, 8'h05, "t1_and", 2);

        // Abort in RUN cycle 4
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
        bus.op    = 2'b01;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        check("t4:busy_run", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("t4:busy",   32'(bus.busy),   32'd0);
        check("t4:done",   32'(bus.done),   32'd0);
        check("t4:result", 32'(bus.result), 32'h05);
        check("t4:cl_a",   32'(cl_a),       32'd0);
        check("t4:cl_s",   32'(cl_s),       32'd0);
        step();
        check("t4:done_later",   32'(bus.done),   32'd0);
        check("t4:result_later", 32'(bus.result), 32'h05);

        // OR / XOR / NOT a
        run_op(8'h81, 8'h18, 2'b01, 8'h99, "t2_or",  -1);
        run_op(8'hFF, 8'h0F, 2'b10, 8'hF0, "t2_xor", -1);
        run_op(8'h3C, 8'hFF, 2'b11, 8'hC3, "t2_not", -1);

        // Reset in RUN cycle 5
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.op    = 2'b01;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        check("t5:busy_run", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        step();
        check("t5:busy",   32'(bus.busy),   32'd0);
        check("t5:done",   32'(bus.done),   32'd0);
        check("t5:result", 32'(bus.result), 32'h0);
        check("t5:cl_a",   32'(cl_a),       32'd0);
        check("t5:cl_b",   32'(cl_b),       32'd0);
        check("t5:cl_s",   32'(cl_s),       32'd0);
        reset = 1'b1;
        last_result = 8'h00;
        step();
        run_op(8'h0F, 8'hF0, 2'b01, 8'hFF, "t5_after", -1);

        // start held high: back-to-back operations, abort on the last bit
        bus.start = 1'b1;
        bus.a     = 8'hA5;
        bus.b     = 8'h0F;
        bus.op    = 2'b00;
        step();
        check("t6:busy_e0", 32'(bus.busy), 32'd1);
        repeat (7) step();
        check("t6:busy_e7", 32'(bus.busy), 32'd1);
        bus.a  = 8'h81;
        bus.b  = 8'h18;
        bus.op = 2'b01;
        step();
        check("t6:done_e8",   32'(bus.done),   32'd1);
        check("t6:result_e8", 32'(bus.result), 32'h05);
        step();
        check("t6:busy_e9", 32'(bus.busy), 32'd0);
        check("t6:done_e9", 32'(bus.done), 32'd0);
        step();
        check("t6:busy_e10", 32'(bus.busy), 32'd1);
        check("t6:cl_s_e10", 32'(cl_s),     32'd1);
        repeat (7) step();
        check("t6:busy_last", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("t6:abort_done",   32'(bus.done),   32'd0);
        check("t6:abort_busy",   32'(bus.busy),   32'd0);
        check("t6:abort_result", 32'(bus.result), 32'h05);
        step();
        check("t6:restart_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        repeat (8) step();
        check("t6:final_done",   32'(bus.done),   32'd1);
        check("t6:final_result", 32'(bus.result), 32'h99);
        step();
        check("t6:final_idle",   32'(bus.done),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
